pipeline_ctrl: RTL

Sequencing controller for the five-stage pipeline registers (PC, F/D, D/E, E/M, M/W). It merges the hazard unit's load-use stall and branch-mispredict flush with two multi-cycle events, data-memory wait and multi-cycle mul/div, and drives one enable and one bubble/flush per stage register. A small FSM holds the pipeline through multi-cycle events, and two saturating performance counters record stall and flush activity.

---
 rtl/pipeline_ctrl_if.sv | 52 +++++
 rtl/pipeline_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_if.sv
// pipeline_ctrl_if
//   Bundles the hazard/multi-cycle event inputs and the per-stage register
//   controls of the pipeline sequencing controller.
//   master : hazard unit / memory / mul-div side (drives events, reads controls)
//   slave  : pipeline_ctrl (reads events, drives controls and status)
//   Signals:
//     load_use, mispredict_e, muldiv_e, muldiv_done, mem_req_m, mem_ready : events
//     pc_en, fd_en, de_en, em_en, mw_en       : stage register enables
//     fd_flush, de_flush, em_flush, mw_flush  : load bubble at next edge
//     muldiv_start                            : one-cycle mul/div start pulse
//     md_timeout                              : sticky mul/div timeout flag
//     stall_cnt, flush_cnt                    : saturating performance counters
//     state                                   : FSM state (RUN=0, MEM_WAIT=1, MD_BUSY=2)
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic                 load_use;
    logic                 mispredict_e;
    logic                 muldiv_e;
    logic                 muldiv_done;
    logic                 mem_req_m;
    logic                 mem_ready;

    logic                 pc_en;
    logic                 fd_en;
    logic                 de_en;
    logic                 em_en;
    logic                 mw_en;
    logic                 fd_flush;
    logic                 de_flush;
    logic                 em_flush;
    logic                 mw_flush;
    logic                 muldiv_start;
    logic                 md_timeout;
    logic [CNT_WIDTH-1:0] stall_cnt;
    logic [CNT_WIDTH-1:0] flush_cnt;
    logic [1:0]           state;

    modport master (
        output load_use, mispredict_e, muldiv_e, muldiv_done, mem_req_m, mem_ready,
        input  pc_en, fd_en, de_en, em_en, mw_en,
        input  fd_flush, de_flush, em_flush, mw_flush,
        input  muldiv_start, md_timeout, stall_cnt, flush_cnt, state
    );

    modport slave (
        input  load_use, mispredict_e, muldiv_e, muldiv_done, mem_req_m, mem_ready,
        output pc_en, fd_en, de_en, em_en, mw_en,
        output fd_flush, de_flush, em_flush, mw_flush,
        output muldiv_start, md_timeout, stall_cnt, flush_cnt, state
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
//   Sequencing controller for the PC, F/D, D/E, E/M and M/W pipeline registers.
//   Merges load-use stall and branch-mispredict flush with data-memory wait and
//   multi-cycle mul/div, and keeps saturating stall/flush counters.
//   Ports:
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : pipeline_ctrl_if.slave (events in, stage controls/status out)
module pipeline_ctrl #(
    parameter int unsigned CNT_WIDTH  = 32,
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    pipeline_ctrl_if.slave  bus
);
    localparam int unsigned TW = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(MD_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        MD_BUSY  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [TW-1:0]        tmo_q, tmo_d;
    logic                 md_timeout_q;
    logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q;

    logic pc_en, fd_en, de_en, em_en, mw_en;
    logic fd_flush, de_flush, em_flush, mw_flush;
    logic muldiv_start;
    logic flush_acc;
    logic set_tmo;

    always_comb begin
        pc_en        = 1'b1;
        fd_en        = 1'b1;
        de_en        = 1'b1;
        em_en        = 1'b1;
        mw_en        = 1'b1;
        fd_flush     = 1'b0;
        de_flush     = 1'b0;
        em_flush     = 1'b0;
        mw_flush     = 1'b0;
        muldiv_start = 1'b0;
        flush_acc    = 1'b0;
        set_tmo      = 1'b0;
        state_d      = state_q;
        tmo_d        = tmo_q;

        case (state_q)
            RUN: begin
                if (bus.mem_req_m && !bus.mem_ready) begin
                    pc_en    = 1'b0;
                    fd_en    = 1'b0;
                    de_en    = 1'b0;
                    em_en    = 1'b0;
                    mw_flush = 1'b1;
                    state_d  = MEM_WAIT;
                end else if (bus.muldiv_e) begin
                    muldiv_start = 1'b1;
                    pc_en        = 1'b0;
                    fd_en        = 1'b0;
                    de_en        = 1'b0;
                    em_flush     = 1'b1;
                    state_d      = MD_BUSY;
                    tmo_d        = '0;
                end else if (bus.mispredict_e) begin
                    fd_flush  = 1'b1;
                    de_flush  = 1'b1;
                    flush_acc = 1'b1;
                end else if (bus.load_use) begin
                    pc_en    = 1'b0;
                    fd_en    = 1'b0;
                    de_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (!bus.mem_ready) begin
                    pc_en    = 1'b0;
                    fd_en    = 1'b0;
                    de_en    = 1'b0;
                    em_en    = 1'b0;
                    mw_flush = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            MD_BUSY: begin
                // A done arriving in the same cycle as the timeout limit counts as
                // a normal completion, so the sticky flag is not raised.
                if (bus.muldiv_done || tmo_q == TMO_LAST) begin
                    state_d = RUN;
                    set_tmo = !bus.muldiv_done;
                end else begin
                    pc_en    = 1'b0;
                    fd_en    = 1'b0;
                    de_en    = 1'b0;
                    em_flush = 1'b1;
                    tmo_d    = tmo_q + TW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RUN;
            tmo_q        <= '0;
            md_timeout_q <= 1'b0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            if (set_tmo) begin
                md_timeout_q <= 1'b1;
            end
            if (!pc_en && stall_cnt_q != '1) begin
                stall_cnt_q <= stall_cnt_q + CNT_WIDTH'(1);
            end
            if (flush_acc && flush_cnt_q != '1) begin
                flush_cnt_q <= flush_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // During reset every register is held and bubbled regardless of the FSM.
    always_comb begin
        bus.pc_en        = rst_n & pc_en;
        bus.fd_en        = rst_n & fd_en;
        bus.de_en        = rst_n & de_en;
        bus.em_en        = rst_n & em_en;
        bus.mw_en        = rst_n & mw_en;
        bus.fd_flush     = !rst_n | fd_flush;
        bus.de_flush     = !rst_n | de_flush;
        bus.em_flush     = !rst_n | em_flush;
        bus.mw_flush     = !rst_n | mw_flush;
        bus.muldiv_start = rst_n & muldiv_start;
        bus.md_timeout   = md_timeout_q;
        bus.stall_cnt    = stall_cnt_q;
        bus.flush_cnt    = flush_cnt_q;
        bus.state        = state_q;
    end
endmodule
